// File: rtl/mic_clk_gen_pkg.sv
// mic_clk_gen shared types and constants.
// FSM state encoding, lock qualification default, synchroniser depth.
`timescale 1ns/1ps
package mic_clk_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN
  } state_t;

  localparam int LOCK_CYCLES_DEF = 1024;
  localparam int SYNC_STAGES     = 2;

endpackage

// File: rtl/mic_clk_gen_if.sv
// mic_clk_gen control/status bundle.
// master = controller side, slave = clock generator.
`timescale 1ns/1ps
interface mic_clk_gen_if #(
  parameter int DIV_W = 8,
  parameter int WS_W  = 8
);

  logic             en;
  logic [DIV_W-1:0] sck_div;
  logic [WS_W-1:0]  ws_len;
  logic             cfg_load;
  logic             sck;
  logic             sck_rise;
  logic             sck_fall;
  logic             ws;
  logic             frame_start;
  logic             rst_mic_n;
  logic             cfg_pending;

  modport master (
    output en, sck_div, ws_len, cfg_load,
    input  sck, sck_rise, sck_fall, ws,
    input  frame_start, rst_mic_n, cfg_pending
  );

  modport slave (
    input  en, sck_div, ws_len, cfg_load,
    output sck, sck_rise, sck_fall, ws,
    output frame_start, rst_mic_n, cfg_pending
  );

endinterface

// File: rtl/mic_clk_gen_lock_sync.sv
// lock_sync: multi-flop synchroniser for the async PLL lock.
// Depth comes from SYNC_STAGES in mic_clk_pkg.
`timescale 1ns/1ps
module lock_sync
  import mic_clk_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sr_q;
  logic [SYNC_STAGES-1:0] sr_d;

  // shift the raw lock in at the bottom
  always_comb begin
    sr_d = {sr_q[SYNC_STAGES-2:0], async_in};
  end

  // synchroniser flops, cleared by reset
  always_ff @(posedge clk_in) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign sync_out = sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/mic_clk_gen.sv
// mic_clk_gen: lock-qualified SCK / WS / frame generator.
// Define MIC_CLK_GEN_WS_PULSE_EN for a one-SCK-period frame-sync ws.
`timescale 1ns/1ps
module mic_clk_gen
  import mic_clk_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int WS_W        = 8,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         pll_lock,
  mic_clk_gen_if.slave bus
);

  localparam int SC_W = $clog2(LOCK_CYCLES + 1);

  logic lock_s;

  lock_sync u_sync (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  state_t            state_q;
  logic [SC_W-1:0]   stab_cnt_q;
  logic              rst_mic_n_q;
  logic              en_q;

  logic              stab_done;
  logic              run_entry;
  logic              run_stay;
  logic              run_next;
  logic              start;

  assign stab_done = stab_cnt_q == SC_W'(LOCK_CYCLES - 1);
  assign run_entry = (state_q == S_STABLE) && lock_s
                   && stab_done;
  assign run_stay  = (state_q == S_RUN) && lock_s;
  assign run_next  = run_entry || run_stay;
  assign start     = bus.en
                   && (run_entry || (run_stay && !en_q));

  // lock qualification FSM; rst_mic_n tracks next state
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      stab_cnt_q  <= '0;
      rst_mic_n_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_HOLD: state_q <= S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q    <= S_STABLE;
            stab_cnt_q <= '0;
          end
        end
        S_STABLE: begin
          if (!lock_s)        state_q <= S_WAIT_LOCK;
          else if (stab_done) state_q <= S_RUN;
          else stab_cnt_q <= stab_cnt_q + 1'b1;
        end
        S_RUN: begin
          if (!lock_s) state_q <= S_WAIT_LOCK;
        end
        default: state_q <= S_HOLD;
      endcase
      rst_mic_n_q <= run_next;
    end
  end

  logic             gen_q, gen_d;
  logic [DIV_W-1:0] sck_cnt_q, sck_cnt_d;
  logic [WS_W-1:0]  ws_cnt_q, ws_cnt_d;
  logic [DIV_W-1:0] div_sh_q, div_sh_d;
  logic [WS_W-1:0]  len_sh_q, len_sh_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [WS_W-1:0]  pend_len_q, pend_len_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             sck_q, sck_d;
  logic             half_q, half_d;
  logic             ws_q, ws_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             fs_q, fs_d;

  logic             half_wrap;
  logic             fall;
  logic             ws_wrap;
  logic             bnd;
  logic             step;

  assign half_wrap = sck_cnt_q == div_sh_q;
  assign fall      = gen_q && sck_q && half_wrap;
  assign ws_wrap   = fall && (ws_cnt_q == len_sh_q);
  assign bnd       = ws_wrap && !half_q;
  assign step      = run_next && gen_q && !start;

  // SCK/WS engine next state and config shadowing
  always_comb begin
    gen_d      = gen_q;
    sck_cnt_d  = sck_cnt_q;
    ws_cnt_d   = ws_cnt_q;
    div_sh_d   = div_sh_q;
    len_sh_d   = len_sh_q;
    pend_div_d = pend_div_q;
    pend_len_d = pend_len_q;
    cfg_pend_d = cfg_pend_q;
    sck_d      = sck_q;
    half_d     = half_q;
    ws_d       = ws_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    fs_d       = 1'b0;
    unique case (1'b1)
      !run_next: begin
        gen_d     = 1'b0;
        sck_cnt_d = '0;
        ws_cnt_d  = '0;
        sck_d     = 1'b0;
        half_d    = 1'b0;
        ws_d      = 1'b0;
      end
      start: begin
        gen_d     = 1'b1;
        div_sh_d  = bus.sck_div;
        len_sh_d  = bus.ws_len;
        sck_cnt_d = '0;
        ws_cnt_d  = '0;
        sck_d     = 1'b0;
        half_d    = 1'b1;
        ws_d      = 1'b1;
        fs_d      = 1'b1;
      end
      step: begin
        if (half_wrap) begin
          sck_cnt_d = '0;
          sck_d     = ~sck_q;
          rise_d    = ~sck_q;
          fall_d    = sck_q;
        end else begin
          sck_cnt_d = sck_cnt_q + 1'b1;
        end
        if (fall) begin
          if (ws_wrap) begin
            ws_cnt_d = '0;
            half_d   = ~half_q;
          end else begin
            ws_cnt_d = ws_cnt_q + 1'b1;
          end
`ifdef MIC_CLK_GEN_WS_PULSE_EN
          ws_d = 1'b0;
`else
          ws_d = half_d;
`endif
        end
        if (bnd) begin
          if (cfg_pend_q) begin
            div_sh_d   = pend_div_q;
            len_sh_d   = pend_len_q;
            cfg_pend_d = 1'b0;
          end
          if (bus.en) begin
            fs_d = 1'b1;
            ws_d = 1'b1;
          end else begin
            gen_d  = 1'b0;
            half_d = 1'b0;
            ws_d   = 1'b0;
          end
        end
      end
      default: ;
    endcase
    // a load on a boundary cycle waits for the next one
    if (bus.cfg_load) begin
      pend_div_d = bus.sck_div;
      pend_len_d = bus.ws_len;
      cfg_pend_d = 1'b1;
    end
  end

  // engine registers
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      gen_q      <= 1'b0;
      sck_cnt_q  <= '0;
      ws_cnt_q   <= '0;
      div_sh_q   <= '0;
      len_sh_q   <= '0;
      pend_div_q <= '0;
      pend_len_q <= '0;
      cfg_pend_q <= 1'b0;
      sck_q      <= 1'b0;
      half_q     <= 1'b0;
      ws_q       <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      en_q       <= bus.en;
      gen_q      <= gen_d;
      sck_cnt_q  <= sck_cnt_d;
      ws_cnt_q   <= ws_cnt_d;
      div_sh_q   <= div_sh_d;
      len_sh_q   <= len_sh_d;
      pend_div_q <= pend_div_d;
      pend_len_q <= pend_len_d;
      cfg_pend_q <= cfg_pend_d;
      sck_q      <= sck_d;
      half_q     <= half_d;
      ws_q       <= ws_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.sck         = sck_q;
  assign bus.sck_rise    = rise_q;
  assign bus.sck_fall    = fall_q;
  assign bus.ws          = ws_q;
  assign bus.frame_start = fs_q;
  assign bus.rst_mic_n   = rst_mic_n_q;
  assign bus.cfg_pending = cfg_pend_q;

endmodule

// File: tb/tb_mic_clk_gen.sv
// tb_mic_clk_gen: directed stimulus, arithmetic reference model
// and literal timing checks for mic_clk_gen.
`timescale 1ns/1ps
module tb_mic_clk_gen;

  localparam int LC = 64;
`ifdef MIC_CLK_GEN_WS_PULSE_EN
  localparam int WS_HI = 6;
`else
  localparam int WS_HI = 24;
`endif

  logic clk;
  logic rst_n;
  logic pll_lock;

  mic_clk_gen_if #(.DIV_W(8), .WS_W(8)) bus ();

  mic_clk_gen #(
    .DIV_W       (8),
    .WS_W        (8),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // reference model state
  int  k = 0;
  bit  m_hold, d1, d2, m_run, en_p, act, fresh;
  bit  pend, stop_pulse;
  int  lk, t0, md, ml, pd, pl;
  bit  e_sck, e_rise, e_fall, e_ws, e_fs, e_rmn, e_pend;

  // model: expected outputs after each rising edge
  always @(posedge clk) begin
    bit prev_run;
    int rel, h, fl, fpos, hw;
    k++;
    stop_pulse = 0;
    if (!rst_n) begin
      m_hold = 1; d1 = 0; d2 = 0; lk = 0;
      m_run = 0; en_p = 0; act = 0; pend = 0;
    end else begin
      // lock is seen two edges late; run needs LC+1 seen edges
      if (m_hold) begin
        m_hold = 0; lk = 0;
      end else if (d2) lk++;
      else lk = 0;
      d2 = d1; d1 = pll_lock;
      prev_run = m_run;
      m_run = lk >= LC + 1;
      if (!m_run) act = 0;
      else if ((!prev_run && bus.en)
               || (prev_run && bus.en && !en_p)) begin
        act = 1; t0 = k; fresh = 1;
        md = int'(bus.sck_div); ml = int'(bus.ws_len);
      end else if (act) begin
        rel = k - t0;
        fl = 4 * (md + 1) * (ml + 1);
        if (rel % fl == 0) begin
          if (pend) begin
            md = pd; ml = pl; pend = 0;
          end
          if (bus.en) begin
            t0 = k; fresh = 0;
          end else begin
            act = 0; stop_pulse = 1;
          end
        end
      end
      if (bus.cfg_load) begin
        pend = 1;
        pd = int'(bus.sck_div); pl = int'(bus.ws_len);
      end
      en_p = bus.en;
    end
    {e_sck, e_rise, e_fall, e_ws, e_fs} = '0;
    if (act) begin
      rel = k - t0;
      h = md + 1;
      fl = 4 * h * (ml + 1);
`ifdef MIC_CLK_GEN_WS_PULSE_EN
      hw = 2 * h;
`else
      hw = 2 * h * (ml + 1);
`endif
      fpos   = rel % fl;
      e_sck  = ((rel / h) % 2) == 1;
      e_rise = (rel % h == 0) && ((rel / h) % 2 == 1);
      e_fall = (rel % h == 0) && ((rel / h) % 2 == 0)
               && !(rel == 0 && fresh);
      e_ws   = fpos < hw;
      e_fs   = fpos == 0;
    end else begin
      e_fall = stop_pulse;
    end
    e_rmn  = m_run;
    e_pend = pend;
  end

  // per-cycle compare away from the active edge
  always @(negedge clk) begin
    logic [6:0] got, exp;
    got = {bus.sck, bus.sck_rise, bus.sck_fall, bus.ws,
           bus.frame_start, bus.rst_mic_n, bus.cfg_pending};
    exp = {e_sck, e_rise, e_fall, e_ws,
           e_fs, e_rmn, e_pend};
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL cyc%0d outputs: got %b expected %b",
               k, got, exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act_v,
                     input int exp_v);
    vectors++;
    if (act_v != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act_v, exp_v);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.frame_start;
      1:       return bus.sck_rise;
      2:       return bus.rst_mic_n;
      default: return !bus.rst_mic_n;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int bound,
                          output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sel(w) && n < bound);
    if (!sel(w)) begin
      vectors++;
      fails++;
      $display("FAIL wait%0d: not seen in %0d cycles", w, bound);
    end
  endtask

  initial begin
    int n, hi, fsc;
    rst_n = 0; pll_lock = 1;
    bus.en = 1; bus.sck_div = 8'd2; bus.ws_len = 8'd3;
    bus.cfg_load = 0;
    repeat (4) tick();
    chk("reset_out", {bus.sck, bus.ws, bus.frame_start,
        bus.rst_mic_n, bus.cfg_pending, bus.sck_rise,
        bus.sck_fall}, 0);
    rst_n = 1;
    wait_sig(2, 300, n);
    chk("lock_to_run", n, LC + 3);
    chk("entry_fs", bus.frame_start, 1);
    chk("entry_ws", bus.ws, 1);

    // basic run: div 2, len 3
    wait_sig(1, 20, n);
    chk("first_rise", n, 3);
    wait_sig(1, 20, n);
    chk("sck_period", n, 6);
    hi = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (bus.ws) hi++;
    end
    chk("ws_high", hi, WS_HI);
    wait_sig(0, 100, n);
    wait_sig(0, 100, n);
    chk("fs_period", n, 48);
    chk("fs_on_fall", bus.sck_fall, 1);

    // reconfig, double load: last value wins
    repeat (10) tick();
    bus.cfg_load = 1; bus.sck_div = 8'd5;
    tick();
    chk("pend_set", bus.cfg_pending, 1);
    bus.sck_div = 8'd0; bus.ws_len = 8'd3;
    tick();
    bus.cfg_load = 0; bus.sck_div = 8'd7; bus.ws_len = 8'd7;
    chk("pend_hold", bus.cfg_pending, 1);
    wait_sig(0, 100, n);
    chk("reconf_fs", n, 36);
    chk("pend_clr", bus.cfg_pending, 0);
    wait_sig(1, 20, n);
    chk("fast_rise", n, 1);
    wait_sig(1, 20, n);
    chk("fast_period", n, 2);
    wait_sig(0, 100, n);
    wait_sig(0, 100, n);
    chk("fast_frame", n, 16);

    // load on the boundary cycle applies one frame later
    repeat (15) tick();
    bus.cfg_load = 1; bus.sck_div = 8'd1; bus.ws_len = 8'd0;
    tick();
    bus.cfg_load = 0; bus.sck_div = 8'd2; bus.ws_len = 8'd3;
    chk("coinc_fs", bus.frame_start, 1);
    chk("coinc_pend", bus.cfg_pending, 1);
    wait_sig(0, 100, n);
    chk("coinc_frame", n, 16);
    chk("coinc_clr", bus.cfg_pending, 0);
    wait_sig(0, 100, n);
    chk("small_frame", n, 8);

    // en drop mid-frame, then restart
    repeat (3) tick();
    bus.en = 0;
    hi = 0; fsc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.sck) hi++;
      if (bus.frame_start) fsc++;
    end
    chk("stop_sck_hi", hi, 2);
    chk("stop_no_fs", fsc, 0);
    bus.en = 1;
    tick();
    chk("restart_fs", bus.frame_start, 1);
    chk("restart_sck", bus.sck, 0);
    wait_sig(0, 100, n);
    chk("restart_frame", n, 48);

    // lock drop in run, then full relock
    repeat (7) tick();
    pll_lock = 0;
    wait_sig(3, 10, n);
    chk("drop_lat", n, 3);
    chk("drop_sck_ws", {bus.sck, bus.ws}, 0);
    pll_lock = 1;
    wait_sig(2, 300, n);
    chk("relock", n, LC + 3);

    // reset mid-frame drops pending config
    repeat (5) tick();
    bus.cfg_load = 1; bus.sck_div = 8'd4;
    tick();
    bus.cfg_load = 0;
    chk("pend_pre_rst", bus.cfg_pending, 1);
    rst_n = 0;
    tick();
    chk("rst_clears", {bus.sck, bus.ws, bus.frame_start,
        bus.rst_mic_n, bus.cfg_pending, bus.sck_rise,
        bus.sck_fall}, 0);
    tick();
    rst_n = 1;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule

// File: doc/mic_clk_gen.md
# mic_clk_gen

Parametrised microphone-array clock generator that replaces fixed divider chains with one runtime-programmable engine. From a single fast system clock it produces the microphone bit clock (SCK), its edge strobes, the word-select/frame signal (WS) and a lock-qualified microphone reset. It sits between the PLL outputs and the mic capture front end, and drives every channel of the array from one timing source.

## Interface
- DIV_W, 8: width of `sck_div`.
- WS_W, 8: width of `ws_len`.
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before release.
- `clk_in` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `pll_lock` input 1: PLL lock, asynchronous; 2-flop synchronised internally.
- `en` input 1: run enable.
- `sck_div` input DIV_W: SCK half-period minus 1, in clk_in cycles.
- `ws_len` input WS_W: SCK periods per WS half-frame minus 1.
- `cfg_load` input 1: single-cycle pulse that captures `sck_div`/`ws_len` into a pending register.
- `sck` output 1: microphone bit clock, registered.
- `sck_rise`, `sck_fall` output 1 each: single-cycle pulses, high in the same cycle `sck` goes high or low.
- `ws` output 1: word select, registered.
- `frame_start` output 1: single-cycle pulse at each frame start.
- `rst_mic_n` output 1: active-low microphone-domain reset.
- `cfg_pending` output 1: a loaded configuration is waiting for a frame boundary.

## Operation
- FSM states: S_HOLD, S_WAIT_LOCK, S_STABLE, S_RUN.
  - S_HOLD: the state during and one cycle after reset. Unconditionally goes to S_WAIT_LOCK.
  - S_WAIT_LOCK: on synchronised lock = 1, go to S_STABLE with the stable counter cleared.
  - S_STABLE: count consecutive lock cycles. When the counter reaches LOCK_CYCLES−1, go to S_RUN. A lock drop returns to S_WAIT_LOCK.
  - S_RUN: a lock drop returns to S_WAIT_LOCK.
- `rst_mic_n` = 1 only in S_RUN.
- In every state except S_RUN, these outputs are forced to 0: `sck`, `ws`, all strobes, and the SCK and WS counters.
- Active configuration lives in shadow registers. `sck_div`/`ws_len` are loaded directly into the shadows on entry to S_RUN and on each en 0→1 restart.
- `cfg_load`:
  - Writes the pending register and sets `cfg_pending`.
  - A second `cfg_load` before the boundary overwrites the pending value; last wins.
  - At the next frame boundary, pending is copied to the shadows and `cfg_pending` clears.
  - A `cfg_load` coinciding with a boundary is captured and applied at the following boundary.
- SCK: a half-period counter counts 0..shadow_div; `sck` toggles at wrap.
  - SCK period = 2·(sck_div+1) clk_in cycles.
  - `sck_div` = 0 gives clk_in/2.
- WS: an SCK-period counter increments on each `sck_fall` and counts 0..shadow_len; `ws` toggles at wrap.
  - Half-frame = ws_len+1 SCK periods.
  - `ws` edges always coincide with `sck_fall`.
- Frame boundary = the `sck_fall` on which `ws` goes 0→1.
- `en`:
  - en 1→0 while running: generation continues to the next frame boundary. At that boundary `sck` and `ws` stay 0, counters clear, and no `frame_start` pulse is issued.
  - en 0→1: a restart.
- Restart and S_RUN entry with en = 1: next cycle `ws` = 1 and `frame_start` = 1, with `sck` = 0 and counters at 0.

## Timing
- Reset values: all outputs 0. FSM in S_HOLD, `cfg_pending` = 0.
- Synchroniser latency: 2 cycles.
- Lock-to-`rst_mic_n` rise: 2 + 1 + LOCK_CYCLES cycles.
- Lock-drop-to-`rst_mic_n` fall: ≤ 3 cycles. `sck`/`ws` are forced to 0 in the same cycle.
- First `sck_rise` occurs sck_div+1 cycles after the first `frame_start`.
- `frame_start` period = 4·(sck_div+1)·(ws_len+1) cycles.
- A `rst_n` assertion mid-frame clears everything on the next clock edge, including pending configuration.

## Configuration
- `MIC_CLK_GEN_WS_PULSE_EN`:
  - Defined: `ws` is a one-SCK-period frame-sync pulse. It goes high at the frame boundary and low at the next `sck_fall`. Frame length = 2·(ws_len+1) SCK periods, unchanged.
  - Undefined: `ws` is the 50% duty word select described above.

## Structure
- Package `mic_clk_pkg`: the FSM state enum, LOCK_CYCLES default, and the synchroniser depth constant.
- One sub-module, `lock_sync`: the 2-flop synchroniser for `pll_lock`.

## Test plan
- Reset/lock: lock held high, `rst_n` released. Expect `rst_mic_n` rise 2+1+LOCK_CYCLES cycles later, with all outputs 0 before that.
- Basic run: `sck_div`=2, `ws_len`=3, en = 1.
  - Expect `sck` period 6 cycles.
  - Expect `ws` high 24 / low 24 cycles.
  - Expect `frame_start` every 48 cycles, aligned with `sck_fall`.
- Reconfig: `cfg_load` with `sck_div`=0 mid-frame.
  - `cfg_pending` = 1 until the boundary.
  - After the boundary, `sck` period is 2 cycles.
  - A double load applies only the last value.
- Lock drop in S_RUN: `rst_mic_n`, `sck` and `ws` go to 0 within 3 cycles. Relock waits a full LOCK_CYCLES again.
- en 1→0 mid-frame: output continues to the boundary, then stays idle. en 0→1 gives `frame_start` the next cycle.
- `MIC_CLK_GEN_WS_PULSE_EN` build: `ws` high exactly 6 cycles per 48-cycle frame, using `sck_div`=2 and `ws_len`=3.
